tsc_fetch_ctrl: RTL and testbench
=================================

# tsc_fetch_ctrl

Sequencing controller for the TSC single-cycle datapath. It runs the instruction-memory read handshake (`readM` / `inputReady`), latches the fetched word and owns the program counter. Once per instruction it raises a one-cycle commit strobe that the datapath uses to gate register-file and output-port writes. It sits between the CPU top level and the datapath, replacing free-running PC update with an explicit FETCH/EXEC sequence.

## Interface
Parameters:
- `WORD_SIZE`, 16, data/address word width
- `TIMEOUT_CYCLES`, 15, FETCH cycles without `inputReady` before fault (only with `FETCH_TIMEOUT_EN`)

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `run_en`  input  1  permits starting a new fetch
- `halt`  input  1  from decode; sampled in EXEC, stops after the current instruction
- `pc_next`  input  WORD_SIZE  next PC computed by datapath from `pc` and `instruction`
- `data`  input  WORD_SIZE  memory read data
- `inputReady`  input  1  memory data valid
- `readM`  output  1  memory read request
- `address`  output  WORD_SIZE  fetch address, equal to `pc`
- `pc`  output  WORD_SIZE  current program counter
- `instruction`  output  WORD_SIZE  latched instruction word
- `inst_valid`  output  1  one-cycle commit strobe; datapath writes only when high
- `num_inst`  output  WORD_SIZE  committed-instruction count
- `halted`  output  1  high in HALT state
- `fetch_err`  output  1  high in ERR state

## Operation
- States:
  - IDLE: enters FETCH when `run_en` is high; otherwise stays in IDLE.
  - FETCH: `readM`=1 and `address`=`pc`. If `inputReady` is high at a clock edge, load `instruction` <= `data` and move to EXEC.
  - EXEC: `inst_valid`=1. At the edge: `pc` <= `pc_next`, `num_inst` <= `num_inst`+1. Next state is HALT if `halt`=1, else FETCH if `run_en`=1, else IDLE.
  - HALT: terminal until reset.
  - ERR: terminal until reset.
- `readM` = (state==FETCH), decoded combinationally from the state register. `inst_valid` = (state==EXEC). `halted` = (state==HALT). `fetch_err` = (state==ERR).
- `inputReady` is ignored outside FETCH. `data` is captured only on the accepting edge. `instruction` holds its value in every other state.
- `halt` and `pc_next` are ignored outside EXEC.
- `num_inst` is modulo 2^WORD_SIZE: 0xFFFF+1 -> 0x0000, no flag.
- `pc` wraps modulo 2^WORD_SIZE; whatever `pc_next` supplies is taken verbatim.
- Dropping `run_en` during FETCH does not abort the fetch. The handshake completes and the instruction executes; the return to IDLE happens after EXEC.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `pc`=0, `instruction`=0, `num_inst`=0. This gives `readM`=0, `inst_valid`=0, `halted`=0, `fetch_err`=0.
- Reset asserted mid-FETCH or mid-EXEC: the in-flight instruction is discarded. There is no commit and no count.
- Minimum of 2 cycles per instruction: `inputReady` high in the first FETCH cycle, then one EXEC cycle.
- `inputReady` already high in the cycle `readM` first rises is accepted at that edge.
- Each additional FETCH cycle adds one cycle of latency.
- `pc`, `address` and `num_inst` change on the edge that ends EXEC. In the EXEC cycle the datapath sees the old `pc` and the new `instruction`.
- Timeout (only when enabled): the counter clears on FETCH entry and increments on each FETCH cycle without `inputReady`.
  - When the counter reaches `TIMEOUT_CYCLES`, the next state is ERR.
  - `inputReady` arriving on that same edge wins and the state goes to EXEC.

## Configuration
- `FETCH_TIMEOUT_EN`:
  - Defined: the timeout counter and ERR transition exist as described above.
  - Undefined: no counter and no ERR state. FETCH waits indefinitely, and `fetch_err` is tied to 0.

## Test plan
- Reset, then `run_en`=1 with `inputReady` held high and `data`=0x1234, `pc_next`=`pc`+1: one commit every 2 cycles; after 3 commits `pc`=3 and `num_inst`=3.
- `inputReady` delayed 4 cycles after `readM` rises: `readM` stays high for 5 cycles; `instruction`=`data` on the accept edge; exactly one `inst_valid` pulse.
- `halt`=1 in EXEC with `pc_next`=0x0ABC: `pc`=0x0ABC, `halted`=1, `readM` stays 0 despite `run_en`=1, until `reset` clears the state to IDLE.
- With `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=15, `inputReady` never asserted: `fetch_err`=1 after 15 FETCH cycles and no commit. Repeat with `inputReady` on the 15th edge: EXEC is entered and `fetch_err` stays 0.
- Preload `num_inst`=0xFFFF, then execute one instruction: `num_inst`=0x0000.
- Assert `reset` mid-FETCH and mid-EXEC: all outputs return to their reset values immediately, with no `inst_valid` pulse and no count increment.

Source files
------------

// File: rtl/tsc_fetch_ctrl.sv
// tsc_fetch_ctrl: FETCH/EXEC sequencer for the TSC datapath. It runs the instruction-memory handshake,
// owns the PC and raises a one-cycle commit strobe. Define FETCH_TIMEOUT_EN to enable the fetch watchdog (ERR state).
module tsc_fetch_ctrl #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_en,
  input  logic                 halt,
  input  logic [WORD_SIZE-1:0] pc_next,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] instruction,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 halted,
  output logic                 fetch_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3
`ifdef FETCH_TIMEOUT_EN
    , ST_ERR = 3'd4
`endif
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [WORD_SIZE-1:0] pc_r;
  logic [WORD_SIZE-1:0] instruction_r;
  logic [WORD_SIZE-1:0] num_inst_r;
  logic                 accept_s;
  logic                 commit_s;

  assign accept_s = (state_r == ST_FETCH) && inputReady;
  assign commit_s = (state_r == ST_EXEC);

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] to_cnt_r;

  // Watchdog: counts FETCH cycles without inputReady; held at zero outside FETCH so it clears on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_r <= '0;
    end else if (state_r != ST_FETCH) begin
      to_cnt_r <= '0;
    end else if (!inputReady) begin
      to_cnt_r <= to_cnt_r + TO_CNT_W'(1);
    end
  end
`endif

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run_en) state_s = ST_FETCH;
        else        state_s = ST_IDLE;
      end
      ST_FETCH: begin
        // a handshake landing on the final watchdog edge still wins
        if (inputReady) begin
          state_s = ST_EXEC;
`ifdef FETCH_TIMEOUT_EN
        end else if (to_cnt_r == TO_LIMIT) begin
          state_s = ST_ERR;
`endif
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (halt)        state_s = ST_HALT;
        else if (run_en) state_s = ST_FETCH;
        else             state_s = ST_IDLE;
      end
      ST_HALT: state_s = ST_HALT;
`ifdef FETCH_TIMEOUT_EN
      ST_ERR:  state_s = ST_ERR;
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Instruction latch, PC and commit counter; reset discards any in-flight instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= '0;
      instruction_r <= '0;
      num_inst_r    <= '0;
    end else begin
      if (accept_s) instruction_r <= data;
      if (commit_s) begin
        pc_r       <= pc_next;
        num_inst_r <= num_inst_r + WORD_SIZE'(1);
      end
    end
  end

  assign readM       = (state_r == ST_FETCH);
  assign inst_valid  = (state_r == ST_EXEC);
  assign halted      = (state_r == ST_HALT);
  assign address     = pc_r;
  assign pc          = pc_r;
  assign instruction = instruction_r;
  assign num_inst    = num_inst_r;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = (state_r == ST_ERR);
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tsc_fetch_ctrl.sv
// Self-checking bench for tsc_fetch_ctrl: scoreboard of fetched words checked at each commit strobe,
// plus per-scenario checks. A second 8-bit instance exercises counter wrap in a short run.
module tb_tsc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        run_en;
  logic        halt;
  logic [15:0] pc_next;
  logic [15:0] data;
  logic        inputReady;
  logic        readM;
  logic [15:0] address;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        inst_valid;
  logic [15:0] num_inst;
  logic        halted;
  logic        fetch_err;

  logic       run8, ready8, halt8;
  logic [7:0] pc_next8, data8;
  logic       readM8, inst_valid8, halted8, fetch_err8;
  logic [7:0] address8, pc8, instruction8, num_inst8;

  tsc_fetch_ctrl #(.WORD_SIZE(16), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .halt(halt), .pc_next(pc_next),
    .data(data), .inputReady(inputReady), .readM(readM), .address(address), .pc(pc),
    .instruction(instruction), .inst_valid(inst_valid), .num_inst(num_inst),
    .halted(halted), .fetch_err(fetch_err)
  );

  tsc_fetch_ctrl #(.WORD_SIZE(8), .TIMEOUT_CYCLES(15)) dut8 (
    .clk(clk), .reset(reset), .run_en(run8), .halt(halt8), .pc_next(pc_next8),
    .data(data8), .inputReady(ready8), .readM(readM8), .address(address8), .pc(pc8),
    .instruction(instruction8), .inst_valid(inst_valid8), .num_inst(num_inst8),
    .halted(halted8), .fetch_err(fetch_err8)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  time         push_t[$];
  int          tests;
  int          fails;
  int          pushes;
  int          model_cnt;
  logic [15:0] model_pc;
  logic        pc_next_ovr_en;
  logic [15:0] pc_next_ovr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // commit monitor: every strobe must match the oldest accepted fetch
  always @(negedge clk) begin
    if (!reset && inst_valid) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected: inst_valid=1 pc=%h instr=%h, expected no commit", pc, instruction);
      end else begin
        mon_e = sb_q.pop_front();
        if (instruction !== mon_e.instr || pc !== mon_e.pc || address !== mon_e.pc) begin
          fails++;
          $display("FAIL commit_data: instr=%h pc=%h addr=%h, expected instr=%h pc=%h",
                   instruction, pc, address, mon_e.instr, mon_e.pc);
        end
        model_cnt++;
      end
    end
  end

  // drive point is the current negedge; record the fetch that the next edge will accept
  task automatic cycle();
    exp_t ne;
    if (readM && inputReady) begin
      pc_next   = pc_next_ovr_en ? pc_next_ovr : model_pc + 16'd1;
      ne.pc     = model_pc;
      ne.instr  = data;
      sb_q.push_back(ne);
      model_pc  = pc_next;
      pushes++;
      push_t.push_back($time);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run_en = 1'b0; inputReady = 1'b0; halt = 1'b0;
    data = 16'h0000; pc_next = 16'h0000; pc_next_ovr_en = 1'b0; pc_next_ovr = 16'h0000;
    run8 = 1'b0; ready8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete(); push_t.delete();
    model_pc = 16'h0000; model_cnt = 0; pushes = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++;
    if ({readM, inst_valid, halted, fetch_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b, expected 0000", {readM, inst_valid, halted, fetch_err});
    end
    tests++;
    if (pc !== 16'h0000 || address !== 16'h0000) begin
      fails++; $display("FAIL reset_pc: pc=%h addr=%h, expected 0000", pc, address);
    end
    tests++;
    if (instruction !== 16'h0000 || num_inst !== 16'h0000 || num_inst8 !== 8'h00) begin
      fails++; $display("FAIL reset_regs: instr=%h num=%h num8=%h, expected 0", instruction, num_inst, num_inst8);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_en = 1'b1; inputReady = 1'b1;
    for (int i = 0; i < 30 && pushes < 3; i++) begin
      data = 16'h1234 + 16'(pushes);
      cycle();
    end
    run_en = 1'b0;
    repeat (3) cycle();
    tests++;
    if (model_cnt !== 3) begin
      fails++; $display("FAIL b2b_commits: %0d commits, expected 3", model_cnt);
    end
    tests++;
    if (pc !== 16'd3 || num_inst !== 16'd3) begin
      fails++; $display("FAIL b2b_pc_count: pc=%h num=%h, expected 0003/0003", pc, num_inst);
    end
    tests++;
    if (push_t.size() != 3 || (push_t[2] - push_t[0]) != 40) begin
      fails++; $display("FAIL b2b_rate: %0d accepts, expected 3 accepts spaced 2 cycles apart", push_t.size());
    end
    tests++;
    if (readM !== 1'b0) begin
      fails++; $display("FAIL b2b_idle: readM=%b, expected 0", readM);
    end
  endtask

  task automatic test_delayed_ready();
    int rd = 0;
    do_reset();
    run_en = 1'b1; data = 16'hBEEF;
    for (int i = 0; i < 12; i++) begin
      if (readM) begin
        rd++;
        if (rd == 2) run_en = 1'b0;
      end
      inputReady = readM && (rd == 5);
      cycle();
    end
    tests++;
    if (rd !== 5) begin
      fails++; $display("FAIL delay_readm_len: readM high %0d cycles, expected 5", rd);
    end
    data = 16'h0000; inputReady = 1'b1;
    repeat (3) cycle();
    tests++;
    if (instruction !== 16'hBEEF || readM !== 1'b0) begin
      fails++; $display("FAIL delay_hold: instr=%h readM=%b, expected BEEF/0", instruction, readM);
    end
    tests++;
    if (model_cnt !== 1 || num_inst !== 16'd1 || pc !== 16'd1) begin
      fails++; $display("FAIL delay_single_commit: commits=%0d num=%h pc=%h, expected 1/0001/0001", model_cnt, num_inst, pc);
    end
  endtask

  task automatic test_halt();
    int nrd = 0;
    do_reset();
    run_en = 1'b1; inputReady = 1'b1; halt = 1'b1; data = 16'hCAFE;
    pc_next_ovr_en = 1'b1; pc_next_ovr = 16'h0ABC;
    for (int i = 0; i < 10; i++) begin
      if (readM) nrd++;
      cycle();
    end
    tests++;
    if (halted !== 1'b1 || readM !== 1'b0 || pc !== 16'h0ABC) begin
      fails++; $display("FAIL halt_state: halted=%b readM=%b pc=%h, expected 1/0/0ABC", halted, readM, pc);
    end
    tests++;
    if (nrd !== 1 || model_cnt !== 1) begin
      fails++; $display("FAIL halt_single: fetch cycles=%0d commits=%0d, expected 1/1", nrd, model_cnt);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (halted !== 1'b0 || pc !== 16'h0000) begin
      fails++; $display("FAIL halt_reset: halted=%b pc=%h, expected 0/0000", halted, pc);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    run_en = 1'b1; inputReady = 1'b0; data = 16'h7777;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 25; i++) begin
      if (readM) n++;
      cycle();
    end
    tests++;
    if (fetch_err !== 1'b1 || n !== 15) begin
      fails++; $display("FAIL timeout_err: fetch_err=%b fetch cycles=%0d, expected 1/15", fetch_err, n);
    end
    tests++;
    if (model_cnt !== 0 || num_inst !== 16'd0 || readM !== 1'b0) begin
      fails++; $display("FAIL timeout_nocommit: commits=%0d num=%h readM=%b, expected 0/0000/0", model_cnt, num_inst, readM);
    end
    do_reset();
    run_en = 1'b1; n = 0; data = 16'h7778;
    for (int i = 0; i < 25; i++) begin
      if (readM) begin
        n++;
        inputReady = (n == 15);
        if (n == 15) run_en = 1'b0;
      end else begin
        inputReady = 1'b0;
      end
      cycle();
    end
    tests++;
    if (fetch_err !== 1'b0 || model_cnt !== 1) begin
      fails++; $display("FAIL timeout_lastedge: fetch_err=%b commits=%0d, expected 0/1", fetch_err, model_cnt);
    end
`else
    for (int i = 0; i < 40; i++) begin
      if (readM) n++;
      cycle();
    end
    tests++;
    if (readM !== 1'b1 || fetch_err !== 1'b0 || n !== 39) begin
      fails++; $display("FAIL nowd_wait: readM=%b fetch_err=%b cycles=%0d, expected 1/0/39", readM, fetch_err, n);
    end
    inputReady = 1'b1; run_en = 1'b0;
    repeat (4) cycle();
    tests++;
    if (model_cnt !== 1 || fetch_err !== 1'b0) begin
      fails++; $display("FAIL nowd_commit: commits=%0d fetch_err=%b, expected 1/0", model_cnt, fetch_err);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    do_reset();
    run_en = 1'b1; inputReady = 1'b1; data = 16'h5A5A;
    for (int i = 0; i < 10 && pushes < 1; i++) cycle();
    inputReady = 1'b0;
    repeat (2) cycle();
    tests++;
    if (readM !== 1'b1 || num_inst !== 16'd1) begin
      fails++; $display("FAIL midfetch_setup: readM=%b num=%h, expected 1/0001", readM, num_inst);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({readM, inst_valid, halted, fetch_err} !== 4'b0000 || pc !== 16'h0000 ||
        num_inst !== 16'h0000 || instruction !== 16'h0000) begin
      fails++; $display("FAIL midfetch_reset: flags=%b pc=%h num=%h instr=%h, expected all 0",
                        {readM, inst_valid, halted, fetch_err}, pc, num_inst, instruction);
    end
    do_reset();
    run_en = 1'b1; inputReady = 1'b1; data = 16'h6B6B;
    for (int i = 0; i < 5 && !readM; i++) @(negedge clk);
    @(posedge clk);
    #2;
    tests++;
    if (inst_valid !== 1'b1) begin
      fails++; $display("FAIL midexec_setup: inst_valid=%b, expected 1", inst_valid);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (inst_valid !== 1'b0 || num_inst !== 16'h0000 || pc !== 16'h0000 || instruction !== 16'h0000) begin
      fails++; $display("FAIL midexec_reset: inst_valid=%b num=%h pc=%h instr=%h, expected 0", inst_valid, num_inst, pc, instruction);
    end
    @(negedge clk);
    tests++;
    if (inst_valid !== 1'b0 || model_cnt !== 0) begin
      fails++; $display("FAIL midexec_nocommit: inst_valid=%b commits=%0d, expected 0/0", inst_valid, model_cnt);
    end
  endtask

  task automatic test_num_inst_wrap();
    int k = 0;
    do_reset();
    pc_next8 = 8'h80; data8 = 8'h3C; halt8 = 1'b0;
    run8 = 1'b1; ready8 = 1'b1;
    for (int i = 0; i < 700 && k < 255; i++) begin
      @(negedge clk);
      if (inst_valid8) begin
        k++;
        if (k == 255) run8 = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    tests++;
    if (num_inst8 !== 8'hFF || k !== 255) begin
      fails++; $display("FAIL wrap_pre: num8=%h commits=%0d, expected FF/255", num_inst8, k);
    end
    run8 = 1'b1;
    for (int i = 0; i < 10 && k < 256; i++) begin
      @(negedge clk);
      if (inst_valid8) begin
        k++;
        run8 = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    tests++;
    if (num_inst8 !== 8'h00 || pc8 !== 8'h80 || instruction8 !== 8'h3C || readM8 !== 1'b0) begin
      fails++; $display("FAIL wrap_post: num8=%h pc8=%h instr8=%h readM8=%b, expected 00/80/3C/0",
                        num_inst8, pc8, instruction8, readM8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish before 100000", $time);
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; pushes = 0; model_cnt = 0; model_pc = 16'h0000;
    reset = 1'b1; run_en = 1'b0; halt = 1'b0; inputReady = 1'b0;
    data = 16'h0000; pc_next = 16'h0000; pc_next_ovr_en = 1'b0; pc_next_ovr = 16'h0000;
    run8 = 1'b0; ready8 = 1'b0; halt8 = 1'b0; pc_next8 = 8'h00; data8 = 8'h00;
    test_reset();
    test_back_to_back();
    test_delayed_ready();
    test_halt();
    test_timeout();
    test_reset_midflight();
    test_num_inst_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
